// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - data bus req/ack handshake between the MEM stage and the memory slave
interface mem_stage_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_ack;
    logic [63:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage: branch resolve, load/store bus FSM, MEM/WB register; bus timeout via MEM_STAGE_TIMEOUT_EN
module mem_stage_ctrl #(
    parameter int unsigned BUS_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] next_pcEXMEM_i,
    input  logic [63:0] alu_resultEXMEM_i,
    input  logic [63:0] store_dataEXMEM_i,
    input  logic [4:0]  rdEXMEM_i,
    input  logic [2:0]  funct3EXMEM_i,
    input  logic        MemtoRegEXMEM_i,
    input  logic        RegWriteEXMEM_i,
    input  logic        BranchEXMEM_i,
    input  logic        MemWriteEXMEM_i,
    input  logic        MemReadEXMEM_i,
    input  logic        zeroEXMEM_i,
    input  logic        lessEXMEM_i,
    mem_stage_ctrl_if.master bus,
    output logic        stall_o,
    output logic        pcsrc_o,
    output logic [63:0] branch_target_o,
    output logic        mem_err_o,
    output logic [63:0] read_dataMEMWB_o,
    output logic [63:0] alu_resultMEMWB_o,
    output logic [4:0]  rdMEMWB_o,
    output logic        MemtoRegMEMWB_o,
    output logic        RegWriteMEMWB_o
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q;
    logic        bus_req_q, bus_we_q, mem_err_q, timed_out_q;
    logic [63:0] bus_addr_q, bus_wdata_q, rdata_q;
    logic [7:0]  bus_wstrb_q;
    logic [63:0] wb_read_q, wb_alu_q;
    logic [4:0]  wb_rd_q;
    logic        wb_m2r_q, wb_rw_q;

    logic        access, misaligned, branch_cond;
    logic [2:0]  off;
    logic [1:0]  size;
    logic [7:0]  wstrb_d;
    logic [63:0] wdata_d, shifted, load_data_d;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = (BUS_TIMEOUT != 0);
`endif

    assign access = MemReadEXMEM_i | MemWriteEXMEM_i;
    assign off    = alu_resultEXMEM_i[2:0];
    assign size   = funct3EXMEM_i[1:0];

    always_comb begin
        misaligned = 1'b0;
        wstrb_d    = 8'hFF;
        case (size)
            2'b00: begin misaligned = 1'b0;          wstrb_d = 8'h01 << off; end
            2'b01: begin misaligned = off[0];        wstrb_d = 8'h03 << off; end
            2'b10: begin misaligned = |off[1:0];     wstrb_d = 8'h0F << off; end
            default: begin misaligned = |off;        wstrb_d = 8'hFF; end
        endcase
    end

    assign wdata_d = store_dataEXMEM_i << {off, 3'b000};
    assign shifted = rdata_q >> {off, 3'b000};

    always_comb begin
        load_data_d = 64'd0;
        case (funct3EXMEM_i)
            3'b000: load_data_d = {{56{shifted[7]}},  shifted[7:0]};
            3'b001: load_data_d = {{48{shifted[15]}}, shifted[15:0]};
            3'b010: load_data_d = {{32{shifted[31]}}, shifted[31:0]};
            3'b011: load_data_d = shifted;
            3'b100: load_data_d = {56'd0, shifted[7:0]};
            3'b101: load_data_d = {48'd0, shifted[15:0]};
            3'b110: load_data_d = {32'd0, shifted[31:0]};
            default: load_data_d = 64'd0;
        endcase
    end

    always_comb begin
        branch_cond = 1'b0;
        case (funct3EXMEM_i)
            3'b000:         branch_cond = zeroEXMEM_i;
            3'b001:         branch_cond = ~zeroEXMEM_i;
            3'b100, 3'b110: branch_cond = lessEXMEM_i;
            3'b101, 3'b111: branch_cond = ~lessEXMEM_i;
            default:        branch_cond = 1'b0;
        endcase
    end

    assign pcsrc_o         = ~rst_i & BranchEXMEM_i & branch_cond;
    assign branch_target_o = next_pcEXMEM_i;
    assign stall_o = ~rst_i & (((state_q == S_IDLE) & access & ~misaligned) | (state_q == S_BUSY));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 64'd0;
            bus_wdata_q <= 64'd0;
            bus_wstrb_q <= 8'd0;
            rdata_q     <= 64'd0;
            mem_err_q   <= 1'b0;
            timed_out_q <= 1'b0;
            wb_read_q   <= 64'd0;
            wb_alu_q    <= 64'd0;
            wb_rd_q     <= 5'd0;
            wb_m2r_q    <= 1'b0;
            wb_rw_q     <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            mem_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (access) begin
                        // Both issued and rejected accesses leave a bubble in MEM/WB.
                        wb_read_q <= 64'd0;
                        wb_alu_q  <= 64'd0;
                        wb_rd_q   <= 5'd0;
                        wb_m2r_q  <= 1'b0;
                        wb_rw_q   <= 1'b0;
                        if (misaligned) begin
                            mem_err_q <= 1'b1;
                        end else begin
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= MemWriteEXMEM_i;
                            bus_addr_q  <= {alu_resultEXMEM_i[63:3], 3'b000};
                            bus_wdata_q <= wdata_d;
                            bus_wstrb_q <= wstrb_d;
                            timed_out_q <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                            state_q     <= S_BUSY;
                        end
                    end else begin
                        wb_read_q <= 64'd0;
                        wb_alu_q  <= alu_resultEXMEM_i;
                        wb_rd_q   <= rdEXMEM_i;
                        wb_m2r_q  <= MemtoRegEXMEM_i;
                        wb_rw_q   <= RegWriteEXMEM_i;
                    end
                end
                S_BUSY: begin
                    if (bus.bus_ack) begin
                        rdata_q   <= bus.bus_rdata;
                        bus_req_q <= 1'b0;
                        state_q   <= S_DONE;
                    end
`ifdef MEM_STAGE_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        bus_req_q   <= 1'b0;
                        mem_err_q   <= 1'b1;
                        timed_out_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    // EX/MEM still holds the access here; it advances on this edge.
                    if (timed_out_q) begin
                        wb_read_q <= 64'd0;
                        wb_alu_q  <= 64'd0;
                        wb_rd_q   <= 5'd0;
                        wb_m2r_q  <= 1'b0;
                        wb_rw_q   <= 1'b0;
                    end else begin
                        wb_read_q <= MemWriteEXMEM_i ? 64'd0 : load_data_d;
                        wb_alu_q  <= alu_resultEXMEM_i;
                        wb_rd_q   <= rdEXMEM_i;
                        wb_m2r_q  <= MemtoRegEXMEM_i;
                        wb_rw_q   <= MemWriteEXMEM_i ? 1'b0 : RegWriteEXMEM_i;
                    end
                    timed_out_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_wstrb = bus_wstrb_q;

    assign mem_err_o         = mem_err_q;
    assign read_dataMEMWB_o  = wb_read_q;
    assign alu_resultMEMWB_o = wb_alu_q;
    assign rdMEMWB_o         = wb_rd_q;
    assign MemtoRegMEMWB_o   = wb_m2r_q;
    assign RegWriteMEMWB_o   = wb_rw_q;
endmodule
